// File: rtl/atm_ledger_arbiter.sv
// atm_ledger_arbiter
//   Owns the shared account ledger. Operations from N_REQ ATM session
//   controllers are arbitrated round-robin. Each one is then run as an
//   atomic IDLE -> CHECK -> COMMIT -> ACK read-modify-write.
// Ports
//   clk, reset_n          : clock (rising edge), async active-low reset
//   req[N_REQ]            : per-requester request, held with its fields until ack
//   req_op/src/dst/amt    : packed per-requester fields (op, src, dst, amount)
//   ack[N_REQ]            : one-cycle completion pulse to the granted requester
//   resp_err, resp_bal    : shared response (error code, post-op source balance)
//   busy                  : high whenever the sequencer is not idle
module atm_ledger_arbiter #(
  parameter int N_REQ    = 2,
  parameter int N_ACC    = 10,
  parameter int BAL_W    = 16,
  parameter int AMT_W    = 11,
  parameter int INIT_BAL = 500
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [2*N_REQ-1:0]     req_op,
  input  logic [4*N_REQ-1:0]     req_src,
  input  logic [4*N_REQ-1:0]     req_dst,
  input  logic [AMT_W*N_REQ-1:0] req_amt,
  output logic [N_REQ-1:0]       ack,
  output logic [1:0]             resp_err,
  output logic [BAL_W-1:0]       resp_bal,
  output logic                   busy
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [1:0] OP_BAL = 2'd0;
  localparam logic [1:0] OP_WD  = 2'd1;
  localparam logic [1:0] OP_DEP = 2'd2;
  localparam logic [1:0] OP_XFR = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_COMMIT, S_ACK} state_e;

  state_e                        state_q;
  logic [PW-1:0]                 ptr_q, win_q;
  logic [1:0]                    op_q;
  logic [3:0]                    src_q, dst_q;
  logic [AMT_W-1:0]              amt_q;
  logic [1:0]                    err_q;
  logic [BAL_W-1:0]              nsrc_q, ndst_q;
  logic [N_ACC-1:0][BAL_W-1:0]   bal_q;

  assign busy = (state_q != S_IDLE);

  // Round-robin grant. Scan the offsets from high to low so that the lowest
  // offset from the pointer is the one that wins.
  logic          gnt_vld;
  logic [PW-1:0] gnt_idx;
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int i = N_REQ-1; i >= 0; i--) begin
      if (req[(int'(ptr_q) + i) % N_REQ]) begin
        gnt_vld = 1'b1;
        gnt_idx = PW'((int'(ptr_q) + i) % N_REQ);
      end
    end
  end

  // Check stage. The inputs are the latched fields only. The sums carry one
  // extra bit, so an overflow shows up as a carry and never wraps.
  logic [BAL_W-1:0] bal_src, bal_dst, nsrc_d;
  logic [BAL_W:0]   amt_x, sum_src, sum_dst;
  logic             src_ok, dst_ok;
  logic [1:0]       err_d;
  always_comb begin
    bal_src = '0;
    bal_dst = '0;
    for (int a = 0; a < N_ACC; a++) begin
      if (src_q == 4'(a)) bal_src = bal_q[a];
      if (dst_q == 4'(a)) bal_dst = bal_q[a];
    end
    src_ok  = (32'(src_q) < 32'(N_ACC));
    dst_ok  = (32'(dst_q) < 32'(N_ACC));
    amt_x   = (BAL_W+1)'(amt_q);
    sum_src = {1'b0, bal_src} + amt_x;
    sum_dst = {1'b0, bal_dst} + amt_x;

    err_d = 2'd0;
    if (!src_ok || (op_q == OP_XFR && !dst_ok))                 err_d = 2'd1;
    else if (op_q == OP_XFR && src_q == dst_q)                  err_d = 2'd3;
    else if ((op_q == OP_WD || op_q == OP_XFR) &&
             amt_x > {1'b0, bal_src})                           err_d = 2'd2;
    else if (op_q == OP_DEP && sum_src[BAL_W])                  err_d = 2'd3;
    else if (op_q == OP_XFR && sum_dst[BAL_W])                  err_d = 2'd3;

    // On an error the response reports the unchanged source balance.
    nsrc_d = bal_src;
    if (err_d == 2'd0) begin
      case (op_q)
        OP_WD, OP_XFR: nsrc_d = bal_src - amt_x[BAL_W-1:0];
        OP_DEP:        nsrc_d = sum_src[BAL_W-1:0];
        default:       nsrc_d = bal_src;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      win_q    <= '0;
      op_q     <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      amt_q    <= '0;
      err_q    <= '0;
      nsrc_q   <= '0;
      ndst_q   <= '0;
      ack      <= '0;
      resp_err <= '0;
      resp_bal <= '0;
      for (int a = 0; a < N_ACC; a++) bal_q[a] <= BAL_W'(INIT_BAL);
    end else begin
      case (state_q)
        S_IDLE: begin
          if (gnt_vld) begin
            win_q   <= gnt_idx;
            op_q    <= req_op [int'(gnt_idx)*2     +: 2];
            src_q   <= req_src[int'(gnt_idx)*4     +: 4];
            dst_q   <= req_dst[int'(gnt_idx)*4     +: 4];
            amt_q   <= req_amt[int'(gnt_idx)*AMT_W +: AMT_W];
            ptr_q   <= PW'((int'(gnt_idx) + 1) % N_REQ);
            state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          err_q   <= err_d;
          nsrc_q  <= nsrc_d;
          ndst_q  <= sum_dst[BAL_W-1:0];
          state_q <= S_COMMIT;
        end
        S_COMMIT: begin
          // Both ledger writes happen on the same edge, or neither happens.
          if (err_q == 2'd0) begin
            for (int a = 0; a < N_ACC; a++) begin
              if (op_q != OP_BAL && src_q == 4'(a)) bal_q[a] <= nsrc_q;
              if (op_q == OP_XFR && dst_q == 4'(a)) bal_q[a] <= ndst_q;
            end
          end
          resp_err    <= err_q;
          resp_bal    <= nsrc_q;
          ack         <= '0;
          ack[win_q]  <= 1'b1;
          state_q     <= S_ACK;
        end
        S_ACK: begin
          ack     <= '0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
